bus_ram: RTL and testbench
==========================

# bus_ram

Word-addressed 16-bit synchronous RAM that sits directly downstream of `core` on its RD/WR/ADDR/DATA bus. It decodes an address window, inserts a configurable number of wait states, and returns read data one registered cycle after the access. The top level drives the bidirectional `DATA` bus from `DATAO` whenever `DOE` is high. An optional power-up fill writes a known pattern into the array.

## Interface

Parameters:
- `ADDR_BITS`, default 10: array depth is 2^ADDR_BITS words; legal range 4..15.
- `BASE`, default 16'h0000: window base; only bits [15:ADDR_BITS] are significant.
- `WAIT`, default 0: wait states per access; legal range 0..15.

Ports:
- `CLK`  in  1: single clock; all state updates on the rising edge.
- `RES`  in  1: asynchronous, active-high reset.
- `RD`  in  1: read request from core.
- `WR`  in  1: write request from core.
- `ADDR`  in  16: word address.
- `DATAI`  in  16: write data, taken from the `DATA` bus.
- `DATAO`  out  16: read data, registered.
- `DOE`  out  1: read data valid; also the top-level tristate enable for `DATA`. Registered.
- `HLT`  out  1: busy/stall indication to core. Registered.

## Operation

- Hit: `hit = (ADDR[15:ADDR_BITS] == BASE[15:ADDR_BITS])`.
- Index into the array: `ADDR[ADDR_BITS-1:0]`.
- Request: `RD | WR` sampled at a rising edge with `hit` true. When `RD` and `WR` are both high, the access is a read and no write occurs. Miss cycles are ignored: no HLT, no DOE, array unchanged.
- Requests are accepted only in state IDLE or RESP. Requests presented while `HLT`=1 are ignored.
- At acceptance the block latches op, index and `DATAI` into internal registers. Core need not hold the bus after the acceptance edge.
- FSM states: CLEAR (only when the macro is defined), IDLE, WAIT, RESP.
- IDLE/RESP, request accepted with WAIT=0:
  - Write: the array is written at this edge; next state IDLE.
  - Read: `DATAO` <= array[index] and `DOE` <= 1; next state RESP.
- IDLE/RESP, request accepted with WAIT>0: `cnt` <= WAIT-1, `HLT` <= 1; next state WAIT.
- IDLE/RESP, no request: `DOE` <= 0; next state IDLE.
- WAIT:
  - `cnt`!=0: decrement `cnt`.
  - `cnt`==0: perform the latched access and set `HLT` <= 0. A read then loads `DATAO`, sets `DOE` <= 1 and goes to RESP. A write goes to IDLE.
- `DATAO` holds its last value when `DOE`=0. Only `DOE` qualifies the data.
- RESP lasts exactly one cycle unless a new request is accepted in that cycle, which allows back-to-back reads.

## Timing

- Reset values: `DATAO`=0, `DOE`=0, `HLT`=0, `cnt`=0. The state resets to IDLE, or to CLEAR when the macro is defined.
- Reset is asynchronous. Asserting it mid-access aborts the latched access; a write still in WAIT is never performed. Array contents are not reset.
- Read latency: `DOE` is high in cycle N+1+WAIT, where N is the acceptance cycle.
- Write latency: the array is updated at edge N+WAIT.
- `HLT` is high in cycles N+1 .. N+WAIT, i.e. exactly WAIT cycles, and is never high when WAIT=0 outside CLEAR.
- Read-after-write to the same word returns the new data whenever the write edge precedes the read edge.
- Maximum throughput: one access per cycle when WAIT=0; one access per WAIT+1 cycles otherwise.

## Configuration

- Macro `BUS_RAM_CLEAR_EN`.
- Defined:
  - After reset release the FSM stays in CLEAR for 2^ADDR_BITS cycles, writing array[i] = i (zero-extended, truncated to 16 bits) with i counting 0 .. 2^ADDR_BITS-1.
  - `HLT`=1 throughout CLEAR, requests are ignored, and the state then moves to IDLE.
  - Reset during CLEAR restarts the fill from i=0.
- Not defined: the CLEAR state and its counter are absent, the state resets to IDLE, and array contents are undefined (X in simulation) until written.

## Test plan

- Reset: hold `RES`=1 for 3 cycles -> `DATAO`=0, `DOE`=0 and `HLT`=0 throughout. With the macro defined, `HLT` rises to 1 after release.
- WAIT=0: write 16'h1234 to 16'h0005, then read 16'h0005 on the next cycle -> `DOE`=1 for exactly one cycle, one cycle after the read edge, with `DATAO`=16'h1234, and `HLT` never high. Back-to-back reads of 5 and 6 -> `DOE` high for 2 consecutive cycles.
- WAIT=2: read 16'h0005 -> `HLT` high for 2 cycles, then `DOE`=1 with 16'h1234 in the third cycle after acceptance. A new `RD` presented while `HLT`=1 is ignored.
- Miss: BASE=0, ADDR_BITS=10; write 16'hBEEF to 16'h8005 -> no `HLT`, no `DOE`; a subsequent read of 16'h0005 still returns 16'h1234. `RD`=`WR`=1 at 16'h0005 with `DATAI`=16'hFFFF -> returns 16'h1234 and the word is unchanged.
- Reset mid-WAIT: WAIT=3; write 16'hAAAA to 16'h0007, pulse `RES` in the 2nd `HLT` cycle -> after reset, reading 16'h0007 does not return 16'hAAAA. It returns 16'h0007 with the macro defined, otherwise its prior value.
- `BUS_RAM_CLEAR_EN`, ADDR_BITS=4: release reset -> `HLT` high for 16 cycles; then reads of addresses 0..15 return 0..15. Reset at fill cycle 8 -> the fill restarts and `HLT` stays high for 16 more cycles.

Source files
------------

// File: rtl/bus_ram.sv
// Word-addressed 16-bit RAM on the core RD/WR bus with address-window decode and WAIT wait states.
// Define BUS_RAM_CLEAR_EN to fill array[i] = i after every reset release.
`timescale 1ns/1ps

// state    | meaning
// ST_CLEAR | power-up fill, one word per cycle, HLT high (BUS_RAM_CLEAR_EN only)
// ST_IDLE  | waiting for a request
// ST_WAIT  | counting wait states for the latched access, HLT high
// ST_RESP  | DOE high for one cycle; a new request may be accepted here
module bus_ram #(
  parameter int          ADDR_BITS = 10,
  parameter logic [15:0] BASE      = 16'h0000,
  parameter int          WAIT      = 0
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        RD,
  input  logic        WR,
  input  logic [15:0] ADDR,
  input  logic [15:0] DATAI,
  output logic [15:0] DATAO,
  output logic        DOE,
  output logic        HLT
);

  localparam int         DEPTH   = 1 << ADDR_BITS;
  localparam logic [3:0] WAIT_M1 = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
`ifdef BUS_RAM_CLEAR_EN
    , ST_CLEAR
`endif
  } state_t;

  logic [15:0]          mem [DEPTH];
  state_t               state;
  logic [3:0]           cnt;
  logic                 op_rd;
  logic [ADDR_BITS-1:0] idx_q;
  logic [15:0]          data_q;
`ifdef BUS_RAM_CLEAR_EN
  logic [ADDR_BITS-1:0] clr_idx;
`endif

  logic                 hit;
  logic [ADDR_BITS-1:0] idx;
  logic                 req;

  assign hit = (ADDR[15:ADDR_BITS] == BASE[15:ADDR_BITS]);
  assign idx = ADDR[ADDR_BITS-1:0];
  // HLT also covers the single IDLE cycle that follows the fill.
  assign req = (RD | WR) & hit & ~HLT & ((state == ST_IDLE) | (state == ST_RESP));

  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_wa;
  logic [15:0]          mem_wd;

  // Gated by RES so an access aborted by reset can never land in the array.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = idx_q;
    mem_wd = data_q;
    if (!RES) begin
      case (state)
        ST_IDLE, ST_RESP: begin
          if (req && !RD && (WAIT == 0)) begin
            mem_we = 1'b1;
            mem_wa = idx;
            mem_wd = DATAI;
          end
        end
        ST_WAIT: begin
          if ((cnt == 4'd0) && !op_rd) mem_we = 1'b1;
        end
`ifdef BUS_RAM_CLEAR_EN
        ST_CLEAR: begin
          mem_we = 1'b1;
          mem_wa = clr_idx;
          mem_wd = 16'(clr_idx);
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
`ifdef BUS_RAM_CLEAR_EN
      state   <= ST_CLEAR;
      clr_idx <= '0;
`else
      state   <= ST_IDLE;
`endif
      DATAO   <= 16'h0000;
      DOE     <= 1'b0;
      HLT     <= 1'b0;
      cnt     <= 4'd0;
      op_rd   <= 1'b0;
      idx_q   <= '0;
      data_q  <= 16'h0000;
    end else begin
      case (state)
`ifdef BUS_RAM_CLEAR_EN
        ST_CLEAR: begin
          HLT     <= 1'b1;
          DOE     <= 1'b0;
          clr_idx <= clr_idx + 1'b1;
          if (&clr_idx) state <= ST_IDLE;
        end
`endif
        ST_IDLE, ST_RESP: begin
          HLT   <= 1'b0;
          DOE   <= 1'b0;
          state <= ST_IDLE;
          if (req) begin
            op_rd  <= RD;
            idx_q  <= idx;
            data_q <= DATAI;
            if (WAIT == 0) begin
              if (RD) begin
                DATAO <= mem[idx];
                DOE   <= 1'b1;
                state <= ST_RESP;
              end
            end else begin
              cnt   <= WAIT_M1;
              HLT   <= 1'b1;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 1'b1;
          end else begin
            HLT <= 1'b0;
            if (op_rd) begin
              DATAO <= mem[idx_q];
              DOE   <= 1'b1;
              state <= ST_RESP;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_ram.sv
// Bench for bus_ram: three instances (WAIT 0/2/3), vector table, directed corner cases, random vs model.
`timescale 1ns/1ps

module tb_bus_ram;

  localparam int NI = 3;
`ifdef BUS_RAM_CLEAR_EN
  localparam int FILL_BOUND = 1100;
`else
  localparam int FILL_BOUND = 20;
`endif

  logic        CLK;
  logic        res   [NI];
  logic        rd    [NI];
  logic        wr    [NI];
  logic [15:0] addr  [NI];
  logic [15:0] datai [NI];
  logic [15:0] datao [NI];
  logic        doe   [NI];
  logic        hlt   [NI];

  int checks = 0;
  int errors = 0;
  int hcnt [NI];
  logic [15:0] mm [NI][16];

  bus_ram #(.ADDR_BITS(10), .BASE(16'h0000), .WAIT(0)) u0 (
    .CLK(CLK), .RES(res[0]), .RD(rd[0]), .WR(wr[0]), .ADDR(addr[0]),
    .DATAI(datai[0]), .DATAO(datao[0]), .DOE(doe[0]), .HLT(hlt[0]));
  bus_ram #(.ADDR_BITS(10), .BASE(16'h0000), .WAIT(2)) u2 (
    .CLK(CLK), .RES(res[1]), .RD(rd[1]), .WR(wr[1]), .ADDR(addr[1]),
    .DATAI(datai[1]), .DATAO(datao[1]), .DOE(doe[1]), .HLT(hlt[1]));
  bus_ram #(.ADDR_BITS(4), .BASE(16'h0000), .WAIT(3)) u3 (
    .CLK(CLK), .RES(res[2]), .RD(rd[2]), .WR(wr[2]), .ADDR(addr[2]),
    .DATAI(datai[2]), .DATAO(datao[2]), .DOE(doe[2]), .HLT(hlt[2]));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int wt(input int i);
    return (i == 0) ? 0 : (i == 1) ? 2 : 3;
  endfunction

  function automatic int fill_exp(input int i);
`ifdef BUS_RAM_CLEAR_EN
    return (i == 2) ? 16 : 1024;
`else
    return (i < 0) ? 1 : 0;
`endif
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [inst %0d]: got %h, expected %h", nm, i, act, exp);
    end
  endtask

  task automatic idle(input int i);
    rd[i]    = 1'b0;
    wr[i]    = 1'b0;
    addr[i]  = 16'($urandom());
    datai[i] = 16'($urandom());
  endtask

  task automatic count_hlt(input int bound);
    for (int i = 0; i < NI; i++) hcnt[i] = 0;
    repeat (bound) begin
      @(negedge CLK);
      for (int i = 0; i < NI; i++) if (hlt[i]) hcnt[i]++;
    end
  endtask

  // One access; jam keeps a competing read on the bus while HLT is high.
  task automatic access(input int i, input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input bit jam, input bit chkd, input logic [15:0] expd);
    int W;
    W = wt(i);
    @(negedge CLK);
    rd[i] = r; wr[i] = w; addr[i] = a; datai[i] = d;
    @(posedge CLK); #1;
    for (int c = 0; c <= W; c++) begin
      if (jam && c < W) begin
        rd[i] = 1'b1; wr[i] = 1'b0; addr[i] = a ^ 16'h0001;
      end else begin
        idle(i);
      end
      chk("acc_hlt", i, 32'(hlt[i]), 32'(c < W));
      chk("acc_doe", i, 32'(doe[i]), 32'(r && (c == W)));
      if (chkd && r && (c == W)) chk("acc_rdata", i, 32'(datao[i]), 32'(expd));
      @(posedge CLK); #1;
    end
    chk("acc_doe_end", i, 32'(doe[i]), 0);
    chk("acc_hlt_end", i, 32'(hlt[i]), 0);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] datai;
    logic        doe;
    logic [15:0] dat;
  } vec_t;

  vec_t tv [17];

  initial begin
    int n;
    int free_e [NI];
    int hlo [NI];
    int hhi [NI];
    int de [NI];
    logic [15:0] dd [NI];
    logic [15:0] last [NI];
    logic r, w;
    int idx;
    logic [15:0] a, d;

    tv[0]  = '{1'b0, 1'b1, 16'h0005, 16'h1234, 1'b0, 16'h0000};
    tv[1]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 16'h1234};
    tv[2]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h1234};
    tv[3]  = '{1'b0, 1'b1, 16'h0006, 16'h5678, 1'b0, 16'h1234};
    tv[4]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 16'h1234};
    tv[5]  = '{1'b1, 1'b0, 16'h0006, 16'h0000, 1'b1, 16'h5678};
    tv[6]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h5678};
    tv[7]  = '{1'b0, 1'b1, 16'h8005, 16'hBEEF, 1'b0, 16'h5678};
    tv[8]  = '{1'b1, 1'b0, 16'h8005, 16'h0000, 1'b0, 16'h5678};
    tv[9]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 16'h1234};
    tv[10] = '{1'b1, 1'b1, 16'h0005, 16'hFFFF, 1'b1, 16'h1234};
    tv[11] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 16'h1234};
    tv[12] = '{1'b0, 1'b1, 16'h0405, 16'h1111, 1'b0, 16'h1234};
    tv[13] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 16'h1234};
    tv[14] = '{1'b0, 1'b1, 16'h0005, 16'hCAFE, 1'b0, 16'h1234};
    tv[15] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 16'hCAFE};
    tv[16] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hCAFE};

    for (int i = 0; i < NI; i++) begin
      res[i] = 1'b1;
      idle(i);
    end

    // reset held for three cycles
    repeat (3) begin
      @(negedge CLK);
      for (int i = 0; i < NI; i++) begin
        chk("rst_doe", i, 32'(doe[i]), 0);
        chk("rst_datao", i, 32'(datao[i]), 0);
        chk("rst_hlt", i, 32'(hlt[i]), 0);
      end
    end
    for (int i = 0; i < NI; i++) res[i] = 1'b0;
    count_hlt(FILL_BOUND);
    for (int i = 0; i < NI; i++) chk("fill_hlt_cycles", i, 32'(hcnt[i]), 32'(fill_exp(i)));

`ifdef BUS_RAM_CLEAR_EN
    for (int j = 0; j < 16; j++) access(2, 1'b1, 1'b0, 16'(j), 16'h0000, 1'b0, 1'b1, 16'(j));
`endif

    // WAIT=0 vector table on u0
    for (int k = 0; k < 17; k++) begin
      @(negedge CLK);
      rd[0] = tv[k].rd; wr[0] = tv[k].wr; addr[0] = tv[k].addr; datai[0] = tv[k].datai;
      @(posedge CLK); #1;
      chk($sformatf("tv%0d_doe", k), 0, 32'(doe[0]), 32'(tv[k].doe));
      chk($sformatf("tv%0d_datao", k), 0, 32'(datao[0]), 32'(tv[k].dat));
      chk($sformatf("tv%0d_hlt", k), 0, 32'(hlt[0]), 0);
    end
    idle(0);

    // WAIT=2 and WAIT=3 accesses, with a read jammed in during HLT
    access(1, 1'b0, 1'b1, 16'h0005, 16'h1234, 1'b0, 1'b0, 16'h0000);
    access(1, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 1'b1, 16'h1234);
    access(2, 1'b0, 1'b1, 16'h0007, 16'hBBBB, 1'b0, 1'b0, 16'h0000);
    access(2, 1'b1, 1'b0, 16'h0007, 16'h0000, 1'b1, 1'b1, 16'hBBBB);

    // reset in the second HLT cycle of a WAIT=3 write
    @(negedge CLK);
    rd[2] = 1'b0; wr[2] = 1'b1; addr[2] = 16'h0007; datai[2] = 16'hAAAA;
    @(posedge CLK); #1;
    idle(2);
    chk("mw_hlt1", 2, 32'(hlt[2]), 1);
    @(posedge CLK); #1;
    chk("mw_hlt2", 2, 32'(hlt[2]), 1);
    res[2] = 1'b1;
    #1;
    chk("mw_rst_hlt", 2, 32'(hlt[2]), 0);
    chk("mw_rst_doe", 2, 32'(doe[2]), 0);
    @(negedge CLK);
    @(negedge CLK);
    res[2] = 1'b0;
    count_hlt(FILL_BOUND);
    chk("mw_refill", 2, 32'(hcnt[2]), 32'(fill_exp(2)));
`ifdef BUS_RAM_CLEAR_EN
    access(2, 1'b1, 1'b0, 16'h0007, 16'h0000, 1'b0, 1'b1, 16'h0007);
`else
    access(2, 1'b1, 1'b0, 16'h0007, 16'h0000, 1'b0, 1'b1, 16'hBBBB);
`endif

`ifdef BUS_RAM_CLEAR_EN
    // reset at fill cycle 8 restarts the fill
    res[2] = 1'b1;
    @(negedge CLK);
    res[2] = 1'b0;
    n = 0;
    for (int k = 0; k < 100 && n < 8; k++) begin
      @(negedge CLK);
      if (hlt[2]) n++;
    end
    chk("fr_pre", 2, 32'(n), 8);
    res[2] = 1'b1;
    #1;
    chk("fr_rst_hlt", 2, 32'(hlt[2]), 0);
    @(negedge CLK);
    res[2] = 1'b0;
    count_hlt(FILL_BOUND);
    chk("fr_refill", 2, 32'(hcnt[2]), 16);
    access(2, 1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b1, 16'h0003);
`endif

    // random phase against a transaction-level model
    for (int i = 0; i < NI; i++) res[i] = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    for (int i = 0; i < NI; i++) res[i] = 1'b0;
    count_hlt(FILL_BOUND);
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < NI; i++) begin
        d = 16'($urandom());
        mm[i][j] = d;
        access(i, 1'b0, 1'b1, 16'(j), d, 1'b0, 1'b0, 16'h0000);
      end
    end
    for (int i = 0; i < NI; i++) begin
      free_e[i] = 0; hlo[i] = 1; hhi[i] = 0; de[i] = -1;
      dd[i] = 16'h0000; last[i] = 16'h0000;
    end
    for (int e = 0; e < 600; e++) begin
      @(negedge CLK);
      for (int i = 0; i < NI; i++) begin
        r   = ($urandom_range(0, 2) == 0);
        w   = ($urandom_range(0, 2) == 0);
        idx = int'($urandom_range(0, 15));
        d   = 16'($urandom());
        if ($urandom_range(0, 3) == 0) a = 16'(idx) | 16'($urandom_range(1, 63) << 10);
        else a = 16'(idx);
        rd[i] = r; wr[i] = w; addr[i] = a; datai[i] = d;
        if ((r || w) && (a[15:4] == 12'h000) && (e >= free_e[i])) begin
          if (r) begin
            de[i] = e + wt(i);
            dd[i] = mm[i][idx];
          end else begin
            mm[i][idx] = d;
          end
          hlo[i]    = e;
          hhi[i]    = e + wt(i) - 1;
          free_e[i] = e + wt(i) + 1;
        end
      end
      @(posedge CLK); #1;
      for (int i = 0; i < NI; i++) begin
        if (e == de[i]) last[i] = dd[i];
        chk("rnd_doe", i, 32'(doe[i]), 32'(e == de[i]));
        chk("rnd_hlt", i, 32'(hlt[i]), 32'((e >= hlo[i]) && (e <= hhi[i])));
        chk("rnd_datao", i, 32'(datao[i]), 32'(last[i]));
      end
    end
    for (int i = 0; i < NI; i++) idle(i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
